// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: INPUT_NUM valid/ready requesters share one registered
// output slot; a one-hot grant drives the data mux and the rotating pointer.
module rr_onehot_arbiter #(
    parameter int INPUT_NUM  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INPUT_NUM-1:0]  req_valid,
    input  logic [DATA_WIDTH-1:0] req_data [0:INPUT_NUM-1],
    output logic [INPUT_NUM-1:0]  req_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [INPUT_NUM-1:0]  out_grant,
    input  logic                  out_ready
);

    localparam logic [INPUT_NUM-1:0] PTR_RST = INPUT_NUM'(1);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [INPUT_NUM-1:0]  out_grant_q, out_grant_d;
    logic [INPUT_NUM-1:0]  ptr_q,       ptr_d;

    logic                  load;
    logic [INPUT_NUM-1:0]  upper_req;
    logic [INPUT_NUM-1:0]  grant;
    logic [INPUT_NUM-1:0]  grant_rot;
    logic [DATA_WIDTH-1:0] mux_data;

    assign load = !out_valid_q || out_ready;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        upper_req = req_valid & ~(ptr_q - PTR_RST);
        if (|upper_req) begin
            grant = upper_req & (~upper_req + PTR_RST);
        end else begin
            grant = req_valid & (~req_valid + PTR_RST);
        end
    end

    assign grant_rot = (grant << 1) | (grant >> (INPUT_NUM - 1));

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            mux_data = mux_data | ({DATA_WIDTH{grant[i]}} & req_data[i]);
        end
    end

    assign req_ready = (load && !reset) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (|req_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_data;
                out_grant_d = grant;
                ptr_d       = grant_rot;
            end else begin
                out_valid_d = 1'b0;
                out_grant_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
            ptr_q       <= PTR_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

    a_ready_onehot0 : assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
    a_grant_onehot0 : assert property (@(posedge clock) disable iff (reset) $onehot0(out_grant_q));
    a_valid_grant   : assert property (@(posedge clock) disable iff (reset) out_valid_q == (|out_grant_q));
    a_ptr_onehot    : assert property (@(posedge clock) disable iff (reset) $onehot(ptr_q));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: vector table, round-robin reference model,
// accept-to-output scoreboard, fairness and mid-operation reset checks.
module tb_rr_onehot_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [W-1:0]  req_data [0:N-1];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [N-1:0]  out_grant;
    logic          out_ready;

    always #5 clock = ~clock;

    rr_onehot_arbiter #(.INPUT_NUM(N), .DATA_WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [N-1:0] grant;
    } sb_item_t;

    typedef struct {
        logic [N-1:0] vld;
        logic         ordy;
        logic [N-1:0] exp_ready;
    } vec_t;

    sb_item_t sb_q[$];
    vec_t     vecs[15];

    int           checks = 0;
    int           errors = 0;
    int           mptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [N-1:0] m_grant;
    logic         bump_en;
    int           wait_cnt;

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N] && g == '0) g[(p + k) % N] = 1'b1;
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns the model's accepted mask.
    task automatic cycle(input logic [N-1:0] vld, input logic ordy,
                         input logic use_tab, input logic [N-1:0] tab_ready,
                         output logic [N-1:0] acc);
        logic [N-1:0] exp_ready;
        logic         load;
        int           win;
        sb_item_t     it;
        req_valid = vld;
        out_ready = ordy;
        #1;
        load      = !m_valid || ordy;
        exp_ready = load ? model_pick(vld, mptr) : '0;
        win = 0;
        for (int i = 0; i < N; i++) if (exp_ready[i]) win = i;
        if (use_tab) check("tab_req_ready", 32'(req_ready), 32'(tab_ready));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_grant", 32'(out_grant), 32'(m_grant));
        check("out_data",  32'(out_data),  32'(m_data));
        if (out_valid && ordy) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=out_valid required=empty at %0t", $time);
            end else begin
                it = sb_q.pop_front();
                check("sb_data",  32'(out_data),  32'(it.data));
                check("sb_grant", 32'(out_grant), 32'(it.grant));
            end
        end
        if (exp_ready != '0) begin
            it.data  = req_data[win];
            it.grant = exp_ready;
            sb_q.push_back(it);
        end
        if (bump_en && req_ready != '0) begin
            if (req_ready[3]) wait_cnt = 0;
            else begin
                wait_cnt++;
                check("fair_wait_le3", 32'(wait_cnt > 3), 32'(0));
            end
        end
        acc = exp_ready;
        @(posedge clock);
        #1;
        if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_data  = req_data[win];
            m_grant = exp_ready;
            mptr    = (win + 1) % N;
            if (bump_en) req_data[win] = req_data[win] + 8'h11;
        end else if (load) begin
            m_valid = 1'b0;
            m_grant = '0;
        end
    endtask

    initial begin
        logic [N-1:0] acc;
        logic [N-1:0] vld;

        vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[6]  = '{4'b0011, 1'b1, 4'b0001};
        vecs[7]  = '{4'b0011, 1'b1, 4'b0010};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000};
        vecs[12] = '{4'b1111, 1'b1, 4'b1000};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000};

        reset     = 1'b1;
        req_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = 8'h10 + 8'(i);
        bump_en  = 1'b0;
        mptr     = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_grant  = '0;
        wait_cnt = 0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_out_grant", 32'(out_grant), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 15; i++) cycle(vecs[i].vld, vecs[i].ordy, 1'b1, vecs[i].exp_ready, acc);

        // Requester 3 always valid; 0-2 only change while idle or just accepted.
        bump_en = 1'b1;
        vld     = 4'b1000;
        acc     = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!vld[i] || acc[i]) vld[i] = 1'($urandom_range(0, 1));
            end
            vld[3] = 1'b1;
            cycle(vld, 1'($urandom_range(0, 3) != 0), 1'b0, '0, acc);
        end
        bump_en = 1'b0;
        for (int c = 0; c < 3; c++) cycle('0, 1'b1, 1'b0, '0, acc);
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        cycle(4'b1111, 1'b1, 1'b0, '0, acc);
        cycle(4'b1111, 1'b0, 1'b1, 4'b0000, acc);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_grant", 32'(out_grant), 32'(0));
        check("midrst_out_data",  32'(out_data),  32'(0));
        check("midrst_req_ready", 32'(req_ready), 32'(0));
        mptr    = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_grant = '0;
        sb_q.delete();
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        cycle(4'b0110, 1'b1, 1'b1, 4'b0010, acc);
        cycle(4'b0110, 1'b1, 1'b1, 4'b0100, acc);
        cycle(4'b0000, 1'b1, 1'b1, 4'b0000, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter sharing one registered output port among INPUT_NUM valid/ready requesters, e.g. functional-unit results competing for a CDB slot.
- Produces a one-hot grant that drives the one-hot data mux internally.
- Captures the winner's data into a single output register with valid/ready backpressure.
- Guarantees starvation-free service: a continuously requesting source waits at most INPUT_NUM-1 grants.

Parameters:
- INPUT_NUM, 16, number of requesters (>=1).
- DATA_WIDTH, 8, payload width per requester.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  INPUT_NUM  per-requester request.
- req_data  input  DATA_WIDTH x [0:INPUT_NUM-1]  unpacked per-requester payload.
- req_ready  output  INPUT_NUM  one-hot (or zero) accept; the transfer occurs on the cycle where req_valid[i] & req_ready[i].
- out_valid  output  1  output register holds a valid item.
- out_data  output  DATA_WIDTH  registered winner payload.
- out_grant  output  INPUT_NUM  one-hot source of the item in out_data; 0 when out_valid=0.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset values (asynchronous, immediate):
  - out_valid=0, out_data=0, out_grant=0.
  - Priority pointer ptr=one-hot bit 0.
  - req_ready=0 while reset is asserted.
- load = !out_valid | out_ready (output register empty or draining this cycle).
- Grant selection (combinational):
  - grant = first set bit of req_valid, scanning upward from the ptr position with wrap INPUT_NUM-1 -> 0.
  - grant is one-hot or zero.
  - req_ready = load ? grant : 0.
- req_ready depends only on req_valid, ptr, out_valid and out_ready, never on req_data.
- On a rising edge when load=1 and |req_valid:
  - out_valid<=1.
  - out_data<=req_data[winner], using one-hot mux semantics.
  - out_grant<=grant.
  - ptr<=grant rotated left by 1 (winner+1, wrapping to bit 0 after bit INPUT_NUM-1).
- On a rising edge when load=1 and no request:
  - out_valid<=0, out_grant<=0.
  - out_data holds its previous value.
  - ptr unchanged.
- Stall (out_valid=1, out_ready=0):
  - All req_ready=0.
  - out_valid, out_data, out_grant and ptr hold.
  - Requesters must keep req_valid/req_data stable until accepted (standard valid/ready rule).
- Latency and throughput:
  - Accepted item appears on out_* the next cycle.
  - Throughput is 1 item/cycle while out_ready=1, including simultaneous drain-and-refill.
- Fairness:
  - Grant order among persistent requesters strictly rotates.
  - A newly asserted lower-index request does not preempt a higher-index request that is next in rotation.
- INPUT_NUM=1: behaves as a single-entry pipeline register; ptr is constant.
- Reset mid-operation discards the held item with no output handshake; ptr returns to bit 0.
- Invariants (checked by assertions):
  - $onehot0(req_ready).
  - $onehot0(out_grant).
  - out_valid == |out_grant.
  - $onehot(ptr).

Test Plan:
- Reset, then req_valid=4'b1111 with data {A0,A1,A2,A3}=8'h10,11,12,13 and out_ready=1 -> req_ready sequence 0001,0010,0100,1000,0001. Outputs one cycle later are 10,11,12,13,10, with out_grant matching.
- ptr at bit 2 (after granting 1), req_valid=4'b0011 -> grant 0001 (wrap), out_data=data[0]. Next grant is 0010.
- Accept item, then drive out_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 throughout, and out_data/out_grant/ptr stable. On out_ready=1, the next winner is accepted the same cycle and out_data updates the following cycle.
- req_valid=0 for 2 cycles with out_ready=1 after one item -> out_valid falls to 0, out_grant=0, out_data holds the last value, ptr unchanged.
- Requester 3 held valid while requesters 0-2 toggle randomly -> requester 3 is granted within 3 grants. A scoreboard checks every accepted item emerges exactly once, in order, with the correct out_grant.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid=0, out_grant=0, out_data=0 immediately. After release, the first grant goes to the lowest set req_valid index.
